// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline definitions: block geometry, default coefficient width,
// read-side FSM states and the zigzag scan table (scan index -> raster address).
package jpeg_pkg;

  localparam int BLK_SIZE    = 64;
  localparam int DATA_W_DFLT = 12;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  function automatic logic [5:0] zz_addr(input logic [5:0] idx);
    logic [5:0] addr;
    case (idx)
      6'd0:  addr = 6'd0;   6'd1:  addr = 6'd1;   6'd2:  addr = 6'd8;   6'd3:  addr = 6'd16;
      6'd4:  addr = 6'd9;   6'd5:  addr = 6'd2;   6'd6:  addr = 6'd3;   6'd7:  addr = 6'd10;
      6'd8:  addr = 6'd17;  6'd9:  addr = 6'd24;  6'd10: addr = 6'd32;  6'd11: addr = 6'd25;
      6'd12: addr = 6'd18;  6'd13: addr = 6'd11;  6'd14: addr = 6'd4;   6'd15: addr = 6'd5;
      6'd16: addr = 6'd12;  6'd17: addr = 6'd19;  6'd18: addr = 6'd26;  6'd19: addr = 6'd33;
      6'd20: addr = 6'd40;  6'd21: addr = 6'd48;  6'd22: addr = 6'd41;  6'd23: addr = 6'd34;
      6'd24: addr = 6'd27;  6'd25: addr = 6'd20;  6'd26: addr = 6'd13;  6'd27: addr = 6'd6;
      6'd28: addr = 6'd7;   6'd29: addr = 6'd14;  6'd30: addr = 6'd21;  6'd31: addr = 6'd28;
      6'd32: addr = 6'd35;  6'd33: addr = 6'd42;  6'd34: addr = 6'd49;  6'd35: addr = 6'd56;
      6'd36: addr = 6'd57;  6'd37: addr = 6'd50;  6'd38: addr = 6'd43;  6'd39: addr = 6'd36;
      6'd40: addr = 6'd29;  6'd41: addr = 6'd22;  6'd42: addr = 6'd15;  6'd43: addr = 6'd23;
      6'd44: addr = 6'd30;  6'd45: addr = 6'd37;  6'd46: addr = 6'd44;  6'd47: addr = 6'd51;
      6'd48: addr = 6'd58;  6'd49: addr = 6'd59;  6'd50: addr = 6'd52;  6'd51: addr = 6'd45;
      6'd52: addr = 6'd38;  6'd53: addr = 6'd31;  6'd54: addr = 6'd39;  6'd55: addr = 6'd46;
      6'd56: addr = 6'd53;  6'd57: addr = 6'd60;  6'd58: addr = 6'd61;  6'd59: addr = 6'd54;
      6'd60: addr = 6'd47;  6'd61: addr = 6'd55;  6'd62: addr = 6'd62;  6'd63: addr = 6'd63;
      default: addr = 6'd0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/zz_block_buffer_if.sv
// Coefficient stream interface of the block buffer: raster-order input side,
// zigzag-order output side and the block-complete pulse.
interface zz_block_buffer_if
  import jpeg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              blk_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, blk_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, blk_done
  );

endinterface

// File: rtl/zz_block_buffer_ramf.sv
// RAMF: simple dual-port storage, synchronous write, read data driven
// combinationally from the (externally registered) read address. Not reset.
module RAMF #(
  parameter int RAMD_W = 12,
  parameter int RAMA_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAMA_W-1:0] waddr,
  input  logic [RAMD_W-1:0] d,
  input  logic [RAMA_W-1:0] raddr,
  output logic [RAMD_W-1:0] q
);

  localparam int DEPTH = 1 << RAMA_W;

  logic [RAMD_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= d;
    end
  end

  assign q = mem_r[raddr];

endmodule

// File: rtl/zz_block_buffer.sv
// Ping-pong 8x8 block buffer: raster-order writes fill one bank while the other
// drains in zigzag order. Macro ZZ_BUF_RASTER_EN adds raster_sel (raster-order drain).
module zz_block_buffer
  import jpeg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int BANK_AW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ZZ_BUF_RASTER_EN
  input  logic             raster_sel,
`endif
  zz_block_buffer_if.slave bus
);

  localparam int                 RAM_AW   = BANK_AW + 1;
  localparam logic [BANK_AW-1:0] IDX_ZERO = {BANK_AW{1'b0}};
  localparam logic [BANK_AW-1:0] IDX_LAST = {BANK_AW{1'b1}};
  localparam logic [BANK_AW:0]   RCNT_ONE = (BANK_AW + 1)'(1);
  localparam logic [BANK_AW:0]   RCNT_END = (BANK_AW + 1)'(BLK_SIZE);

  function automatic logic [BANK_AW-1:0] rd_map(input logic raster,
                                                input logic [BANK_AW-1:0] idx);
    logic [BANK_AW-1:0] addr;
    if (raster) begin
      addr = idx;
    end else begin
      addr = zz_addr(idx);
    end
    return addr;
  endfunction

  rd_state_e          state_r, state_s;
  logic               wbank_r, wbank_s;
  logic               rbank_r, rbank_s;
  logic [BANK_AW-1:0] wcnt_r, wcnt_s;
  logic [BANK_AW-1:0] disp_idx_r, disp_idx_s;
  logic [BANK_AW:0]   rcnt_r, rcnt_s;
  logic [RAM_AW-1:0]  raddr_r, raddr_s;
  logic [1:0]         bank_full_r, bank_full_s;
  logic               out_valid_r, out_valid_s;
  logic               out_last_r, out_last_s;
  logic               blk_done_r, blk_done_s;
  logic               in_ready_r, in_ready_s;
  logic               raster_r, raster_s;
  logic               raster_in_s;
  logic               wr_fire_s, fill_done_s, advance_s, last_xfer_s, other_full_s;
  logic [DATA_W-1:0]  ram_q_s;

`ifdef ZZ_BUF_RASTER_EN
  assign raster_in_s = raster_sel;
`else
  assign raster_in_s = 1'b0;
`endif

  // Handshake qualifiers; a bank completing this cycle counts as full for a seamless switch
  always_comb begin
    wr_fire_s    = bus.in_valid && in_ready_r;
    fill_done_s  = wr_fire_s && (wcnt_r == IDX_LAST);
    advance_s    = !out_valid_r || bus.out_ready;
    last_xfer_s  = out_valid_r && bus.out_ready && (disp_idx_r == IDX_LAST);
    other_full_s = bank_full_r[~rbank_r] || (fill_done_s && (wbank_r != rbank_r));
  end

  // Next-state logic for the write counter, bank flags and read FSM
  always_comb begin
    state_s     = state_r;
    wbank_s     = wbank_r;
    rbank_s     = rbank_r;
    wcnt_s      = wcnt_r;
    disp_idx_s  = disp_idx_r;
    rcnt_s      = rcnt_r;
    raddr_s     = raddr_r;
    bank_full_s = bank_full_r;
    out_valid_s = out_valid_r;
    raster_s    = raster_r;
    blk_done_s  = 1'b0;

    if (wr_fire_s) begin
      wcnt_s = wcnt_r + 1'b1;
    end else begin
      wcnt_s = wcnt_r;
    end

    if (fill_done_s) begin
      wbank_s              = ~wbank_r;
      bank_full_s[wbank_r] = 1'b1;
      blk_done_s           = 1'b1;
    end else begin
      blk_done_s = 1'b0;
    end

    case (state_r)
      RD_IDLE: begin
        if (bank_full_r[rbank_r]) begin
          state_s     = RD_STREAM;
          raster_s    = raster_in_s;
          raddr_s     = {rbank_r, rd_map(raster_in_s, IDX_ZERO)};
          disp_idx_s  = IDX_ZERO;
          rcnt_s      = RCNT_ONE;
          out_valid_s = 1'b1;
        end else begin
          out_valid_s = 1'b0;
        end
      end
      RD_STREAM: begin
        if (advance_s) begin
          if (last_xfer_s) begin
            bank_full_s[rbank_r] = 1'b0;
            rbank_s              = ~rbank_r;
            if (other_full_s) begin
              raster_s    = raster_in_s;
              raddr_s     = {~rbank_r, rd_map(raster_in_s, IDX_ZERO)};
              disp_idx_s  = IDX_ZERO;
              rcnt_s      = RCNT_ONE;
              out_valid_s = 1'b1;
            end else begin
              state_s     = RD_IDLE;
              rcnt_s      = {(BANK_AW + 1){1'b0}};
              out_valid_s = 1'b0;
            end
          end else if (rcnt_r < RCNT_END) begin
            raddr_s     = {rbank_r, rd_map(raster_r, rcnt_r[BANK_AW-1:0])};
            disp_idx_s  = rcnt_r[BANK_AW-1:0];
            rcnt_s      = rcnt_r + RCNT_ONE;
            out_valid_s = 1'b1;
          end else begin
            rcnt_s = rcnt_r;
          end
        end else begin
          // Stall: raddr held so q and out_data remain stable
          raddr_s = raddr_r;
        end
      end
      default: begin
        state_s     = RD_IDLE;
        out_valid_s = 1'b0;
      end
    endcase

    in_ready_s = ~bank_full_s[wbank_s];
    out_last_s = out_valid_s && (disp_idx_s == IDX_LAST);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RD_IDLE;
      wbank_r     <= 1'b0;
      rbank_r     <= 1'b0;
      wcnt_r      <= {BANK_AW{1'b0}};
      disp_idx_r  <= {BANK_AW{1'b0}};
      rcnt_r      <= {(BANK_AW + 1){1'b0}};
      raddr_r     <= {RAM_AW{1'b0}};
      bank_full_r <= 2'b00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      blk_done_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      raster_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      wbank_r     <= wbank_s;
      rbank_r     <= rbank_s;
      wcnt_r      <= wcnt_s;
      disp_idx_r  <= disp_idx_s;
      rcnt_r      <= rcnt_s;
      raddr_r     <= raddr_s;
      bank_full_r <= bank_full_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      blk_done_r  <= blk_done_s;
      in_ready_r  <= in_ready_s;
      raster_r    <= raster_s;
    end
  end

  RAMF #(
    .RAMD_W (DATA_W),
    .RAMA_W (RAM_AW)
  ) u_ramf (
    .clk   (clk),
    .we    (wr_fire_s),
    .waddr ({wbank_r, wcnt_r}),
    .d     (bus.in_data),
    .raddr (raddr_r),
    .q     (ram_q_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_data  = ram_q_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.blk_done  = blk_done_r;

endmodule
